// File: rtl/vm2002_coin_acceptor_if.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_coin_acceptor_if
// Purpose  : Coin, credit handshake and change signals between the vending
//            controller side (master) and the coin acceptor (slave).
// Revision : 1.0  initial release
// ============================================================================
interface vm2002_coin_acceptor_if #(
    parameter int CREDIT_W = 10
);
    logic                insert_coins;
    logic                select;
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                credit_ack;
    logic                credit_nack;
    logic [CREDIT_W-1:0] charge;
    logic [CREDIT_W-1:0] credit;
    logic                credit_valid;
    logic                start_timer;
    logic                timeout;
    logic                coin_reject;
    logic                change_pulse;
    logic [1:0]          change_type;
    logic                busy;

    modport master (
        output insert_coins, select, coin_valid, coin_type,
               credit_ack, credit_nack, charge,
        input  credit, credit_valid, start_timer, timeout,
               coin_reject, change_pulse, change_type, busy
    );

    modport slave (
        input  insert_coins, select, coin_valid, coin_type,
               credit_ack, credit_nack, charge,
        output credit, credit_valid, start_timer, timeout,
               coin_reject, change_pulse, change_type, busy
    );
endinterface
`default_nettype wire

// File: rtl/vm2002_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_coin_acceptor
// Purpose  : Coin collection, selection timer, credit hand-off and greedy
//            coin-by-coin change/refund payout for the vm2002 controller.
// Revision : 1.0  initial release
// ============================================================================
module vm2002_coin_acceptor #(
    parameter int CREDIT_W       = 10,
    parameter int MAX_CREDIT     = 500,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         hrst,
    input  logic                         srst,
    vm2002_coin_acceptor_if.slave        bus
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]    c_tmr_load = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CREDIT_W:0]   c_max_ext  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] c_nickel   = CREDIT_W'(5);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [TMR_W-1:0]    r_timer, w_timer_nxt;
    logic                r_credit_valid, r_start_timer, r_busy;
    logic                r_timeout, w_timeout_nxt;
    logic                r_coin_reject, w_coin_reject_nxt;
    logic                r_change_pulse, w_change_pulse_nxt;
    logic [1:0]          r_change_type, w_change_type_nxt;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic [1:0]          w_ref_type;
    logic [CREDIT_W-1:0] w_ref_val;

    always_comb begin
        w_coin_val = CREDIT_W'(5);
        case (bus.coin_type)
            2'b00:   w_coin_val = CREDIT_W'(5);
            2'b01:   w_coin_val = CREDIT_W'(10);
            2'b10:   w_coin_val = CREDIT_W'(25);
            default: w_coin_val = CREDIT_W'(100);
        endcase
    end

    assign w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};

    // Greedy payout: largest denomination that still fits in the credit
    always_comb begin
        w_ref_type = 2'b00;
        w_ref_val  = CREDIT_W'(5);
        if (r_credit >= CREDIT_W'(100)) begin
            w_ref_type = 2'b11;
            w_ref_val  = CREDIT_W'(100);
        end else if (r_credit >= CREDIT_W'(25)) begin
            w_ref_type = 2'b10;
            w_ref_val  = CREDIT_W'(25);
        end else if (r_credit >= CREDIT_W'(10)) begin
            w_ref_type = 2'b01;
            w_ref_val  = CREDIT_W'(10);
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_timer_nxt        = r_timer;
        w_timeout_nxt      = 1'b0;
        w_coin_reject_nxt  = bus.coin_valid;
        w_change_pulse_nxt = 1'b0;
        w_change_type_nxt  = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (bus.insert_coins) begin
                    w_state_nxt = S_COLLECT;
                    w_timer_nxt = c_tmr_load;
                end
            end

            S_COLLECT: begin
                if (srst) begin
                    w_state_nxt = (r_credit != '0) ? S_REFUND : S_IDLE;
                end else if (r_timer == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = (r_credit != '0) ? S_REFUND : S_IDLE;
                end else begin
                    if (bus.coin_valid && (w_sum <= c_max_ext)) begin
                        w_credit_nxt      = w_sum[CREDIT_W-1:0];
                        w_timer_nxt       = c_tmr_load;
                        w_coin_reject_nxt = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                    if (bus.select && (w_credit_nxt != '0)) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (srst) begin
                    w_state_nxt = S_REFUND;
                end else if (bus.credit_nack ||
                             (bus.credit_ack && (bus.charge > r_credit))) begin
                    w_state_nxt = S_COLLECT;
                    w_timer_nxt = c_tmr_load;
                end else if (bus.credit_ack) begin
                    w_credit_nxt = r_credit - bus.charge;
                    w_state_nxt  = (bus.charge != r_credit) ? S_REFUND : S_IDLE;
                end
            end

            S_REFUND: begin
                // Pulse on alternate cycles; sub-nickel remainder is forfeited
                if (!r_change_pulse && (r_credit >= c_nickel)) begin
                    w_change_pulse_nxt = 1'b1;
                    w_change_type_nxt  = w_ref_type;
                    w_credit_nxt       = r_credit - w_ref_val;
                end else if (r_credit < c_nickel) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge hrst) begin
        if (hrst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_timer        <= '0;
            r_credit_valid <= 1'b0;
            r_start_timer  <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_change_pulse <= 1'b0;
            r_change_type  <= 2'b00;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_timer        <= w_timer_nxt;
            r_credit_valid <= (w_state_nxt == S_HOLD);
            r_start_timer  <= (w_state_nxt == S_COLLECT);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_timeout      <= w_timeout_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
            r_change_pulse <= w_change_pulse_nxt;
            r_change_type  <= w_change_type_nxt;
        end
    end

    assign bus.credit       = r_credit;
    assign bus.credit_valid = r_credit_valid;
    assign bus.start_timer  = r_start_timer;
    assign bus.timeout      = r_timeout;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.change_pulse = r_change_pulse;
    assign bus.change_type  = r_change_type;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vm2002_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm2002_coin_acceptor
// Purpose  : Self-checking bench; expected change coins queued at stimulus
//            time and popped as the acceptor issues change pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_vm2002_coin_acceptor;

    localparam int CW   = 10;
    localparam int MAXC = 500;
    localparam int TMO  = 1000;

    logic clk  = 1'b0;
    logic hrst = 1'b1;
    logic srst = 1'b0;

    always #5 clk = ~clk;

    vm2002_coin_acceptor_if #(.CREDIT_W(CW)) bus ();

    vm2002_coin_acceptor #(
        .CREDIT_W      (CW),
        .MAX_CREDIT    (MAXC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .hrst(hrst),
        .srst(srst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int exp_credit = 0;
    bit exp_collect = 1'b0;
    bit prev_pulse = 1'b0;
    int mon_exp;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int coin_value(input logic [1:0] t);
        case (t)
            2'b00:   return 5;
            2'b01:   return 10;
            2'b10:   return 25;
            default: return 100;
        endcase
    endfunction

    function automatic void push_refund(input int amt);
        int a;
        a = amt;
        while (a >= 5) begin
            if (a >= 100)     begin exp_q.push_back(3); a -= 100; end
            else if (a >= 25) begin exp_q.push_back(2); a -= 25;  end
            else if (a >= 10) begin exp_q.push_back(1); a -= 10;  end
            else              begin exp_q.push_back(0); a -= 5;   end
        end
    endfunction

    // Change scoreboard: every pulse must match the next queued coin and be
    // separated from the previous pulse by at least one low cycle.
    always @(negedge clk) begin
        if (bus.change_pulse) begin
            check_value("change_gap", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
                check_value("change_unexpected", int'(bus.change_pulse), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_value("change_type", int'(bus.change_type), mon_exp);
            end
        end
        prev_pulse = bus.change_pulse;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_collect();
        bus.insert_coins = 1'b1;
        tick();
        bus.insert_coins = 1'b0;
        exp_collect = 1'b1;
        check_value("start_timer_on", int'(bus.start_timer), 1);
        check_value("busy_on", int'(bus.busy), 1);
    endtask

    task automatic coin(input logic [1:0] t);
        int v;
        bit acc;
        v   = coin_value(t);
        acc = exp_collect && (exp_credit + v <= MAXC);
        bus.coin_valid = 1'b1;
        bus.coin_type  = t;
        tick();
        bus.coin_valid = 1'b0;
        if (acc) exp_credit += v;
        check_value("coin_credit", int'(bus.credit), exp_credit);
        check_value("coin_reject", int'(bus.coin_reject), int'(!acc));
    endtask

    task automatic press_select();
        bus.select = 1'b1;
        tick();
        bus.select = 1'b0;
        exp_collect = 1'b0;
        check_value("hold_valid", int'(bus.credit_valid), 1);
        check_value("hold_credit", int'(bus.credit), exp_credit);
        check_value("hold_timer_off", int'(bus.start_timer), 0);
    endtask

    task automatic respond(input bit ack, input bit nack, input int chg);
        bus.credit_ack  = ack;
        bus.credit_nack = nack;
        bus.charge      = CW'(chg);
        tick();
        bus.credit_ack  = 1'b0;
        bus.credit_nack = 1'b0;
        check_value("valid_drop", int'(bus.credit_valid), 0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (bus.busy && n < max_cycles) begin
            tick();
            n++;
        end
        check_value("idle_reached", int'(bus.busy), 0);
        check_value("idle_credit", int'(bus.credit), 0);
        check_value("change_all_paid", exp_q.size(), 0);
        exp_credit  = 0;
        exp_collect = 1'b0;
    endtask

    initial begin
        bit saw_to;
        bus.insert_coins = 1'b0;
        bus.select       = 1'b0;
        bus.coin_valid   = 1'b0;
        bus.coin_type    = 2'b00;
        bus.credit_ack   = 1'b0;
        bus.credit_nack  = 1'b0;
        bus.charge       = '0;

        // Reset state
        tick();
        tick();
        check_value("rst_credit", int'(bus.credit), 0);
        check_value("rst_busy", int'(bus.busy), 0);
        check_value("rst_timer", int'(bus.start_timer), 0);
        check_value("rst_valid", int'(bus.credit_valid), 0);
        hrst = 1'b0;
        tick();

        // Hard reset mid-COLLECT with 35 cents: asynchronous clear
        start_collect();
        coin(2'b10);
        coin(2'b01);
        hrst = 1'b1;
        #2;
        check_value("hrst_busy", int'(bus.busy), 0);
        check_value("hrst_credit", int'(bus.credit), 0);
        check_value("hrst_timer", int'(bus.start_timer), 0);
        check_value("hrst_reject", int'(bus.coin_reject), 0);
        tick();
        hrst = 1'b0;
        exp_credit  = 0;
        exp_collect = 1'b0;
        tick();

        // Purchase 45 with 60 inserted: change 10 then 5
        start_collect();
        coin(2'b10);
        coin(2'b10);
        coin(2'b01);
        press_select();
        push_refund(15);
        respond(1'b1, 1'b0, 45);
        check_value("ack_credit", int'(bus.credit), 15);
        check_value("ack_busy", int'(bus.busy), 1);
        tick();
        check_value("first_change_pulse", int'(bus.change_pulse), 1);
        wait_idle(20);

        // Insufficient credit paths, then exact payment
        start_collect();
        coin(2'b10);
        press_select();
        respond(1'b0, 1'b1, 0);
        exp_collect = 1'b1;
        check_value("nack_timer", int'(bus.start_timer), 1);
        coin(2'b11);
        press_select();
        respond(1'b1, 1'b0, 200);
        exp_collect = 1'b1;
        check_value("overcharge_collect", int'(bus.start_timer), 1);
        press_select();
        respond(1'b1, 1'b1, 125);
        exp_collect = 1'b1;
        check_value("acknack_collect", int'(bus.start_timer), 1);
        check_value("acknack_credit", int'(bus.credit), 125);
        press_select();
        respond(1'b1, 1'b0, 125);
        check_value("exact_idle", int'(bus.busy), 0);
        wait_idle(4);

        // Timeout exactly TMO cycles after the last accepted coin
        start_collect();
        coin(2'b01);
        saw_to = 1'b0;
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            if (bus.timeout) saw_to = 1'b1;
        end
        check_value("timeout_early", int'(saw_to), 0);
        check_value("timer_running", int'(bus.start_timer), 1);
        push_refund(10);
        bus.coin_valid = 1'b1;
        bus.coin_type  = 2'b01;
        tick();
        bus.coin_valid = 1'b0;
        check_value("timeout_pulse", int'(bus.timeout), 1);
        check_value("timeout_coin_reject", int'(bus.coin_reject), 1);
        check_value("timeout_timer_off", int'(bus.start_timer), 0);
        check_value("timeout_credit", int'(bus.credit), 10);
        tick();
        check_value("timeout_single", int'(bus.timeout), 0);
        wait_idle(20);

        // Credit ceiling
        start_collect();
        for (int k = 0; k < 4; k++) coin(2'b11);
        coin(2'b10);
        coin(2'b10);
        coin(2'b11);
        coin(2'b10);
        coin(2'b10);
        check_value("ceiling_credit", int'(bus.credit), 500);
        coin(2'b00);
        push_refund(500);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_value("cancel_collect_busy", int'(bus.busy), 1);
        check_value("cancel_collect_timer", int'(bus.start_timer), 0);
        wait_idle(40);

        // Cancel from HOLD with 135: refund 100, 25, 10; srst ignored in payout
        start_collect();
        coin(2'b11);
        coin(2'b10);
        coin(2'b01);
        press_select();
        push_refund(135);
        srst = 1'b1;
        tick();
        check_value("cancel_hold_valid", int'(bus.credit_valid), 0);
        check_value("cancel_hold_credit", int'(bus.credit), 135);
        bus.coin_valid = 1'b1;
        tick();
        bus.coin_valid = 1'b0;
        check_value("refund_coin_reject", int'(bus.coin_reject), 1);
        tick();
        tick();
        srst = 1'b0;
        check_value("refund_continues", int'(bus.busy), 1);
        wait_idle(30);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vm2002_coin_acceptor.md
# vm2002_coin_acceptor

Coin-handling front end that sits directly upstream of the vm2002 vending controller. It accepts coins while the controller has `insert_coins` raised, runs the selection timer, presents accumulated credit to the controller with a valid/ack handshake, and returns change or refunds coin by coin. It drives the `start_timer` and `timeout` signals that the controller and bench observe.

## Interface
- `CREDIT_W`, 10: credit/charge width in cents.
- `MAX_CREDIT`, 500: credit ceiling in cents; any coin that would exceed it is rejected.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `hrst`  in  1  hard reset, asynchronous, active-high.
- `srst`  in  1  user cancel, synchronous, active-high.
- `insert_coins`  in  1  controller requests coin collection.
- `select`  in  1  user pressed select.
- `coin_valid`  in  1  one-cycle coin-detect strobe.
- `coin_type`  in  2  00=5, 01=10, 10=25, 11=100 cents.
- `credit_ack`  in  1  controller accepts credit; `charge` is deducted.
- `credit_nack`  in  1  controller reports insufficient credit.
- `charge`  in  CREDIT_W  item cost, sampled with `credit_ack`.
- `credit`  out  CREDIT_W  current credit.
- `credit_valid`  out  1  credit presented (HOLD state).
- `start_timer`  out  1  high while the selection window runs (COLLECT).
- `timeout`  out  1  one-cycle pulse on window expiry.
- `coin_reject`  out  1  one-cycle pulse; coin bounced.
- `change_pulse`  out  1  one-cycle strobe per returned coin.
- `change_type`  out  2  denomination of the returned coin (same encoding as `coin_type`).
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, COLLECT, HOLD, REFUND. All outputs are registered. On `hrst`: IDLE, credit 0, timer 0, every output 0, and any pending credit is lost.
- IDLE: `insert_coins`=1 -> COLLECT and timer loads `TIMEOUT_CYCLES-1`. Coins in IDLE are rejected.
- COLLECT: `start_timer`=1. A coin is accepted if `credit+value <= MAX_CREDIT`. An accepted coin adds its value and reloads the timer. Otherwise the coin is rejected.
- COLLECT exits, priority high to low:
  - `srst` -> REFUND if credit>0, else IDLE. A coin in the same cycle is rejected.
  - Timer at 0 with no coin accepted this cycle -> `timeout` pulse; REFUND if credit>0, else IDLE. A coin in the same cycle is rejected.
  - `select` with post-coin credit>0 -> HOLD. A coin in the same cycle is accepted and included in credit.
  - `select` with credit 0 is ignored.
- HOLD: `credit_valid`=1, `start_timer`=0, coins rejected, timer frozen. Exits:
  - `srst` -> REFUND (full refund).
  - `credit_ack` with `charge <= credit`: credit -= charge, then REFUND if the remainder >0, else IDLE.
  - `credit_ack` with `charge > credit`: treated as `credit_nack`.
  - `credit_nack` -> COLLECT, timer reloaded.
  - `credit_ack` and `credit_nack` both high: nack wins.
- REFUND: pays out greedily, largest denomination first (100, 25, 10, 5). One `change_pulse` per 2 cycles (high 1 cycle, low 1 cycle). Credit is decremented in the same cycle the pulse is driven. When credit <5 -> credit forced to 0 (sub-nickel remainder forfeited) -> IDLE. `srst` and `insert_coins` are ignored; coins are rejected.
- Arithmetic: unsigned CREDIT_W. Credit never exceeds `MAX_CREDIT` and never underflows.

## Timing
- Coin accept: `coin_valid` at edge N -> `credit` updated at N+1. Reject: `coin_reject` high for cycle N+1 only.
- Timeout: with no accepted coin after entering COLLECT at edge E, `timeout` is high for the single cycle after edge E+TIMEOUT_CYCLES. `start_timer` drops at that same edge.
- `select` at edge N -> `credit_valid` high from N+1. Ack/nack sampled at edge M -> `credit_valid` low at M+1.
- First `change_pulse` appears at the edge after REFUND is entered. `busy` falls on the edge that enters IDLE.
- `hrst` mid-payout: pulses stop immediately (asynchronous); no further change is issued.

## Test plan
- Hard reset: assert `hrst` mid-COLLECT with credit 35 -> all outputs 0, state IDLE, `busy`=0 before the next rising edge.
- Coins 25, 25, 10 then `select`; ack with `charge`=45 -> `credit_valid` high with credit 60; after ack, change: one 10, one 5; then IDLE, credit 0.
- Insufficient credit: credit 25, select, nack -> back to COLLECT with `start_timer`=1; add 100, select, ack with `charge`=125 -> IDLE, no change pulses.
- Timeout: one 10-cent coin, then idle for `TIMEOUT_CYCLES` -> single `timeout` pulse at the exact cycle, one 10-cent change pulse, IDLE. A coin strobed in the expiry cycle -> `coin_reject`.
- Ceiling: credit 450, insert 100 -> reject with credit unchanged; insert 25, 25 -> credit 500; a further 5 is rejected.
- Cancel: credit 135 in HOLD, pulse `srst` -> refund 100, 25, 10 in order with 1-cycle gaps; `srst` during payout ignored; IDLE afterwards.
